// File: rtl/cp_pkg.sv
// ---------------------------------------------------------------------------
// cp_pkg
// Shared definitions for the cp_core host-side DMA controller:
//   - default datapath and DMEM address widths
//   - job length width (one more bit than the address so a full DMEM sweep
//     of 2^DMEM_ADDR_WIDTH words can be expressed)
//   - controller FSM state encoding
// ---------------------------------------------------------------------------
package cp_pkg;

  localparam int CP_D_WIDTH_DEF      = 72;
  localparam int DMEM_ADDR_WIDTH_DEF = 10;
  localparam int LEN_WIDTH_DEF       = DMEM_ADDR_WIDTH_DEF + 1;

  typedef logic [LEN_WIDTH_DEF-1:0] cp_len_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_UNLOAD,
    ST_DRAIN
  } cp_state_e;

endpackage

// File: rtl/cp_dma_ctrl_if.sv
// ---------------------------------------------------------------------------
// cp_dma_ctrl_if
// Host-facing bundle of the DMA controller:
//   cmd_*   : job command (valid/ready) with load/unload base and length
//   in_*    : operand stream into DMEM (valid/ready/data)
//   out_*   : result stream out of DMEM (valid/ready/data)
//   cp_nbusy: core not-busy status, forwarded to the host unchanged
// Modports: master = host side, slave = controller side.
// ---------------------------------------------------------------------------
interface cp_dma_ctrl_if #(
  parameter int D_W = 72,
  parameter int A_W = 10
);

  logic           cmd_valid;
  logic           cmd_ready;
  logic [A_W-1:0] cmd_ld_base;
  logic [A_W:0]   cmd_ld_len;
  logic [A_W-1:0] cmd_st_base;
  logic [A_W:0]   cmd_st_len;

  logic           in_valid;
  logic           in_ready;
  logic [D_W-1:0] in_data;

  logic           out_valid;
  logic           out_ready;
  logic [D_W-1:0] out_data;

  logic           cp_nbusy;

  modport master (
    output cmd_valid, cmd_ld_base, cmd_ld_len, cmd_st_base, cmd_st_len,
    input  cmd_ready,
    output in_valid, in_data,
    input  in_ready,
    input  out_valid, out_data,
    output out_ready,
    input  cp_nbusy
  );

  modport slave (
    input  cmd_valid, cmd_ld_base, cmd_ld_len, cmd_st_base, cmd_st_len,
    output cmd_ready,
    input  in_valid, in_data,
    output in_ready,
    output out_valid, out_data,
    input  out_ready,
    output cp_nbusy
  );

endinterface

// File: rtl/cp_skid_buf.sv
// ---------------------------------------------------------------------------
// cp_skid_buf
// Two-entry valid/ready buffer for the DMEM unload stream. When empty, an
// arriving word falls straight through to the output in the same cycle, so a
// DMEM read issued at cycle t can be presented at t+1.
// Ports:
//   clock, nreset          : clock, synchronous active-low reset
//   push_valid, push_data  : returned DMEM read data (no ready: the caller
//                            limits buffered + in-flight reads to 2)
//   pop_valid, pop_ready,
//   pop_data               : output stream
//   occupancy              : number of words held in storage (0..2)
// ---------------------------------------------------------------------------
module cp_skid_buf #(
  parameter int WIDTH = 72
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data,
  output logic [1:0]       occupancy
);

  logic [WIDTH-1:0] mem_q [2];
  logic [1:0]       count_q, count_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             store, take;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    pop_valid = (count_q != 2'd0) || push_valid;
    pop_data  = '0;
    if (count_q != 2'd0) begin
      pop_data = mem_q[rd_ptr_q];
    end else if (push_valid) begin
      pop_data = push_data;
    end
    take     = pop_ready && (count_q != 2'd0);
    // Bypass: an empty buffer with a ready consumer stores nothing.
    store    = push_valid && !((count_q == 2'd0) && pop_ready);
    count_d  = count_q + {1'b0, store} - {1'b0, take};
    rd_ptr_d = rd_ptr_q ^ take;
    wr_ptr_d = wr_ptr_q ^ store;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // NOTE: storage is not reset; count_q alone decides which entries are
  // meaningful, and an empty buffer drives zero on pop_data.
  always_ff @(posedge clock) begin
    if (store) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign occupancy = count_q;

endmodule

// File: rtl/cp_dma_ctrl.sv
// ---------------------------------------------------------------------------
// cp_dma_ctrl
// Host-side launcher for one cp_core: accepts a job, loads operands into
// DMEM, runs the core until cp_done (or watchdog expiry), then unloads
// results through a 2-entry skid buffer.
// Ports:
//   clock, nreset            : clock, synchronous active-low reset
//   host (slave)             : command, operand and result streams, status
//   dmem_addr_d/in_d/we_d    : registered DMEM load write port
//   dmem_addr_e, dmem_out_e  : DMEM unload read port (1-cycle read latency)
//   cp_active                : registered core run enable
//   cp_nbusy                 : core not-busy, forwarded to host as status
//   cp_done                  : core completion (registered inside the core)
//   job_done                 : one-cycle completion pulse
//   job_timeout              : sticky watchdog flag, cleared on next command
// ---------------------------------------------------------------------------
module cp_dma_ctrl
  import cp_pkg::*;
#(
  parameter int CP_D_WIDTH      = CP_D_WIDTH_DEF,
  parameter int DMEM_ADDR_WIDTH = DMEM_ADDR_WIDTH_DEF,
  parameter int WDOG_WIDTH      = 20
) (
  input  logic                       clock,
  input  logic                       nreset,
  cp_dma_ctrl_if.slave               host,
  output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr_d,
  output logic [CP_D_WIDTH-1:0]      dmem_in_d,
  output logic                       dmem_we_d,
  output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr_e,
  input  logic [CP_D_WIDTH-1:0]      dmem_out_e,
  output logic                       cp_active,
  input  logic                       cp_nbusy,
  input  logic                       cp_done,
  output logic                       job_done,
  output logic                       job_timeout
);

  localparam int AW = DMEM_ADDR_WIDTH;
  localparam int LW = DMEM_ADDR_WIDTH + 1;
  // Last RUN cycle value of the watchdog: 2^WDOG_WIDTH-1 RUN cycles total.
  localparam logic [WDOG_WIDTH-1:0] WDOG_LAST = {{(WDOG_WIDTH-1){1'b1}}, 1'b0};

  cp_state_e             state_q, state_d;
  logic [AW-1:0]         ld_base_q, ld_base_d, st_base_q, st_base_d;
  logic [LW-1:0]         ld_len_q, ld_len_d, st_len_q, st_len_d;
  logic [LW-1:0]         ld_cnt_q, ld_cnt_d, st_cnt_q, st_cnt_d;
  logic [WDOG_WIDTH-1:0] wdog_q, wdog_d;
  logic                  rd_inflight_q, rd_inflight_d;
  logic                  cp_active_q, cp_active_d;
  logic                  job_done_q, job_done_d;
  logic                  job_timeout_q, job_timeout_d;
  logic                  ld_we_q, ld_we_d;
  logic [AW-1:0]         ld_addr_q, ld_addr_d;
  logic [CP_D_WIDTH-1:0] ld_data_q, ld_data_d;

  logic                  in_ready;
  logic                  rd_issue;
  logic                  drained;
  logic [1:0]            skid_occ;

  // LOAD stays one cycle past the last beat (in_ready low) so the final
  // registered write lands before the core's first RUN cycle.
  assign in_ready = (state_q == ST_LOAD) && (ld_cnt_q != ld_len_q);
  // Reads are throttled so returned data can never overflow the skid buffer.
  assign rd_issue = (state_q == ST_UNLOAD) && (st_cnt_q != st_len_q) &&
                    (({1'b0, skid_occ} + {2'b00, rd_inflight_q}) < 3'd2);
  assign drained  = (skid_occ == 2'd0) && !rd_inflight_q;

  always_comb begin
    state_d       = state_q;
    ld_base_d     = ld_base_q;
    ld_len_d      = ld_len_q;
    st_base_d     = st_base_q;
    st_len_d      = st_len_q;
    ld_cnt_d      = ld_cnt_q;
    st_cnt_d      = st_cnt_q;
    wdog_d        = wdog_q;
    job_done_d    = 1'b0;
    job_timeout_d = job_timeout_q;
    ld_we_d       = 1'b0;
    ld_addr_d     = ld_addr_q;
    ld_data_d     = ld_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (host.cmd_valid) begin
          ld_base_d     = host.cmd_ld_base;
          ld_len_d      = host.cmd_ld_len;
          st_base_d     = host.cmd_st_base;
          st_len_d      = host.cmd_st_len;
          ld_cnt_d      = '0;
          st_cnt_d      = '0;
          wdog_d        = '0;
          job_timeout_d = 1'b0;
          state_d       = (host.cmd_ld_len != '0) ? ST_LOAD : ST_RUN;
        end
      end
      ST_LOAD: begin
        if (in_ready && host.in_valid) begin
          ld_we_d   = 1'b1;
          ld_addr_d = ld_base_q + ld_cnt_q[AW-1:0];
          ld_data_d = host.in_data;
          ld_cnt_d  = ld_cnt_q + 1'b1;
        end
        if (ld_cnt_q == ld_len_q) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        wdog_d = wdog_q + 1'b1;
        if (cp_done) begin
          state_d = (st_len_q != '0) ? ST_UNLOAD : ST_DRAIN;
        end else if (wdog_q == WDOG_LAST) begin
          job_timeout_d = 1'b1;
          state_d       = ST_DRAIN;
        end
      end
      ST_UNLOAD: begin
        if (rd_issue) begin
          st_cnt_d = st_cnt_q + 1'b1;
        end
        if (st_cnt_d == st_len_q) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drained) begin
          job_done_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rd_inflight_d = rd_issue;
    cp_active_d   = (state_d == ST_RUN);
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q       <= ST_IDLE;
      ld_base_q     <= '0;
      ld_len_q      <= '0;
      st_base_q     <= '0;
      st_len_q      <= '0;
      ld_cnt_q      <= '0;
      st_cnt_q      <= '0;
      wdog_q        <= '0;
      rd_inflight_q <= 1'b0;
      cp_active_q   <= 1'b0;
      job_done_q    <= 1'b0;
      job_timeout_q <= 1'b0;
      ld_we_q       <= 1'b0;
      ld_addr_q     <= '0;
      ld_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      ld_base_q     <= ld_base_d;
      ld_len_q      <= ld_len_d;
      st_base_q     <= st_base_d;
      st_len_q      <= st_len_d;
      ld_cnt_q      <= ld_cnt_d;
      st_cnt_q      <= st_cnt_d;
      wdog_q        <= wdog_d;
      rd_inflight_q <= rd_inflight_d;
      cp_active_q   <= cp_active_d;
      job_done_q    <= job_done_d;
      job_timeout_q <= job_timeout_d;
      ld_we_q       <= ld_we_d;
      ld_addr_q     <= ld_addr_d;
      ld_data_q     <= ld_data_d;
    end
  end

  cp_skid_buf #(
    .WIDTH (CP_D_WIDTH)
  ) u_skid (
    .clock      (clock),
    .nreset     (nreset),
    .push_valid (rd_inflight_q),
    .push_data  (dmem_out_e),
    .pop_valid  (host.out_valid),
    .pop_ready  (host.out_ready),
    .pop_data   (host.out_data),
    .occupancy  (skid_occ)
  );

  assign host.cmd_ready = (state_q == ST_IDLE);
  assign host.in_ready  = in_ready;
  assign host.cp_nbusy  = cp_nbusy;

  assign dmem_addr_d = ld_addr_q;
  assign dmem_in_d   = ld_data_q;
  assign dmem_we_d   = ld_we_q;
  assign dmem_addr_e = st_base_q + st_cnt_q[AW-1:0];
  assign cp_active   = cp_active_q;
  assign job_done    = job_done_q;
  assign job_timeout = job_timeout_q;

endmodule

// File: tb/tb_cp_dma_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cp_dma_ctrl
// Directed bench for cp_dma_ctrl with a DMEM model (registered read) and a
// stub core that raises cp_done a programmable number of cycles after
// cp_active rises (0 = never). Watchdog width is reduced to 6 bits.
// ---------------------------------------------------------------------------
module tb_cp_dma_ctrl;

  localparam int DW = 72;
  localparam int AW = 10;

  logic          clock = 1'b0;
  logic          nreset;
  logic [AW-1:0] dmem_addr_d, dmem_addr_e;
  logic [DW-1:0] dmem_in_d, dmem_out_e;
  logic          dmem_we_d, cp_active, cp_done, job_done, job_timeout;
  logic          cp_nbusy;

  cp_dma_ctrl_if #(.D_W(DW), .A_W(AW)) host ();

  cp_dma_ctrl #(
    .CP_D_WIDTH      (DW),
    .DMEM_ADDR_WIDTH (AW),
    .WDOG_WIDTH      (6)
  ) dut (
    .clock       (clock),
    .nreset      (nreset),
    .host        (host),
    .dmem_addr_d (dmem_addr_d),
    .dmem_in_d   (dmem_in_d),
    .dmem_we_d   (dmem_we_d),
    .dmem_addr_e (dmem_addr_e),
    .dmem_out_e  (dmem_out_e),
    .cp_active   (cp_active),
    .cp_nbusy    (cp_nbusy),
    .cp_done     (cp_done),
    .job_done    (job_done),
    .job_timeout (job_timeout)
  );

  always #5 clock = ~clock;

  // DMEM model: registered write, 1-cycle registered read.
  logic [DW-1:0] mem [1024];
  always @(posedge clock) begin
    if (dmem_we_d) mem[dmem_addr_d] <= dmem_in_d;
    dmem_out_e <= mem[dmem_addr_e];
  end

  // Stub core.
  int done_delay;
  int core_cnt;
  assign cp_nbusy = !cp_active;
  always @(posedge clock) begin
    if (!cp_active) begin
      core_cnt <= 0;
      cp_done  <= 1'b0;
    end else begin
      core_cnt <= core_cnt + 1;
      cp_done  <= (done_delay != 0) && (core_cnt == done_delay - 1);
    end
  end

  // Result-side ready: constant high or toggling every cycle.
  logic toggle_mode;
  logic rdy_phase = 1'b0;
  always @(posedge clock) rdy_phase <= ~rdy_phase;
  assign host.out_ready = toggle_mode ? rdy_phase : 1'b1;

  // Monitors, sampled on the falling edge.
  logic [AW-1:0] wr_addr [$];
  logic [DW-1:0] wr_data [$];
  logic [DW-1:0] out_q   [$];
  int            done_cnt = 0, active_cycles = 0, active_rises = 0;
  int            ov_cycles = 0, stall_viol = 0, max_outstanding = 0, cur_out;
  logic          active_prev = 1'b0, stall_prev = 1'b0;
  logic [DW-1:0] stall_data;

  always @(negedge clock) begin
    if (!nreset) begin
      active_prev = 1'b0;
      stall_prev  = 1'b0;
    end else begin
      if (dmem_we_d) begin
        wr_addr.push_back(dmem_addr_d);
        wr_data.push_back(dmem_in_d);
      end
      if (host.out_valid) ov_cycles++;
      if (host.out_valid && host.out_ready) out_q.push_back(host.out_data);
      if (stall_prev && (!host.out_valid || host.out_data !== stall_data)) stall_viol++;
      stall_prev = host.out_valid && !host.out_ready;
      stall_data = host.out_data;
      if (job_done) done_cnt++;
      if (cp_active) active_cycles++;
      if (cp_active && !active_prev) active_rises++;
      active_prev = cp_active;
      cur_out = int'(dut.skid_occ) + int'(dut.rd_inflight_q);
      if (cur_out > max_outstanding) max_outstanding = cur_out;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int seed, input int k);
    logic [31:0] s, kk;
    s  = seed;
    kk = k;
    return {8'hA5, s, kk};
  endfunction

  task automatic issue_cmd(input logic [AW-1:0] lb, input logic [AW:0] ll,
                           input logic [AW-1:0] sb, input logic [AW:0] sl);
    int n = 0;
    host.cmd_valid   = 1'b1;
    host.cmd_ld_base = lb;
    host.cmd_ld_len  = ll;
    host.cmd_st_base = sb;
    host.cmd_st_len  = sl;
    @(negedge clock);
    while (!host.cmd_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("cmd_accept", host.cmd_ready, 1);
    @(posedge clock);
    #1 host.cmd_valid = 1'b0;
  endtask

  task automatic stream_in(input int n, input int seed);
    for (int k = 0; k < n; k++) begin
      int w = 0;
      host.in_valid = 1'b1;
      host.in_data  = pat(seed, k);
      @(negedge clock);
      while (!host.in_ready && w < 100) begin
        @(negedge clock);
        w++;
      end
      check($sformatf("in_beat%0d", k), host.in_ready, 1);
      @(posedge clock);
      #1;
    end
    host.in_valid = 1'b0;
  endtask

  task automatic wait_job_done(input string tag);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < 2000) begin
      @(posedge clock);
      n++;
    end
    check({tag, "_done_in_time"}, done_cnt != start, 1);
    repeat (4) @(posedge clock);
    #1;
  endtask

  initial begin
    int w0, o0, d0, a0, r0, v0;
    for (int i = 0; i < 1024; i++) mem[i] = {8'hEE, 32'h0, 22'h0, i[9:0]};
    nreset           = 1'b0;
    host.cmd_valid   = 1'b0;
    host.cmd_ld_base = '0;
    host.cmd_ld_len  = '0;
    host.cmd_st_base = '0;
    host.cmd_st_len  = '0;
    host.in_valid    = 1'b0;
    host.in_data     = '0;
    toggle_mode      = 1'b0;
    done_delay       = 10;

    // Reset state.
    repeat (2) @(posedge clock);
    #1 nreset = 1'b1;
    @(negedge clock);
    check("rst_cmd_ready",   host.cmd_ready, 1);
    check("rst_in_ready",    host.in_ready, 0);
    check("rst_out_valid",   host.out_valid, 0);
    check("rst_out_data",    host.out_data, 0);
    check("rst_dmem_we_d",   dmem_we_d, 0);
    check("rst_dmem_addr_d", dmem_addr_d, 0);
    check("rst_dmem_in_d",   dmem_in_d, 0);
    check("rst_dmem_addr_e", dmem_addr_e, 0);
    check("rst_cp_active",   cp_active, 0);
    check("rst_job_done",    job_done, 0);
    check("rst_job_timeout", job_timeout, 0);
    @(posedge clock);
    #1;

    // Test 1: wrap-around load/unload of 4 words at 0x3FE.
    w0 = wr_addr.size(); o0 = out_q.size(); d0 = done_cnt; a0 = active_cycles;
    issue_cmd(10'h3FE, 11'd4, 10'h3FE, 11'd4);
    stream_in(4, 1);
    wait_job_done("t1");
    check("t1_wr_count", wr_addr.size() - w0, 4);
    check("t1_wr_addr0", wr_addr[w0 + 0], 10'h3FE);
    check("t1_wr_addr1", wr_addr[w0 + 1], 10'h3FF);
    check("t1_wr_addr2", wr_addr[w0 + 2], 10'h000);
    check("t1_wr_addr3", wr_addr[w0 + 3], 10'h001);
    for (int k = 0; k < 4; k++) check($sformatf("t1_wr_data%0d", k), wr_data[w0 + k], pat(1, k));
    check("t1_out_count", out_q.size() - o0, 4);
    for (int k = 0; k < 4; k++) check($sformatf("t1_out%0d", k), out_q[o0 + k], pat(1, k));
    check("t1_done_pulses", done_cnt - d0, 1);
    check("t1_active_cycles", active_cycles - a0, 11);
    check("t1_timeout", job_timeout, 0);

    // Test 2: empty load and unload.
    w0 = wr_addr.size(); d0 = done_cnt; a0 = active_cycles; v0 = ov_cycles;
    issue_cmd(10'h010, 11'd0, 10'h010, 11'd0);
    wait_job_done("t2");
    check("t2_active_cycles", active_cycles - a0, 11);
    check("t2_no_writes", wr_addr.size() - w0, 0);
    check("t2_no_out_valid", ov_cycles - v0, 0);
    check("t2_done_pulses", done_cnt - d0, 1);

    // Test 3: unload 8 words with out_ready toggling.
    o0 = out_q.size(); r0 = stall_viol;
    toggle_mode = 1'b1;
    issue_cmd(10'h100, 11'd8, 10'h100, 11'd8);
    stream_in(8, 3);
    wait_job_done("t3");
    toggle_mode = 1'b0;
    check("t3_out_count", out_q.size() - o0, 8);
    for (int k = 0; k < 8; k++) check($sformatf("t3_out%0d", k), out_q[o0 + k], pat(3, k));
    check("t3_stall_hold", stall_viol - r0, 0);
    check("t3_max_outstanding_le2", max_outstanding <= 2, 1);

    // Test 4: watchdog expiry, then a new command clears the flag.
    done_delay = 0;
    o0 = out_q.size(); d0 = done_cnt; a0 = active_cycles;
    issue_cmd(10'h000, 11'd0, 10'h300, 11'd2);
    wait_job_done("t4");
    check("t4_active_cycles", active_cycles - a0, 63);
    check("t4_timeout_set", job_timeout, 1);
    check("t4_done_pulses", done_cnt - d0, 1);
    check("t4_no_unload", out_q.size() - o0, 0);
    done_delay = 3;
    issue_cmd(10'h000, 11'd0, 10'h000, 11'd0);
    @(negedge clock);
    check("t4_timeout_cleared", job_timeout, 0);
    @(posedge clock);
    #1;
    wait_job_done("t4b");

    // Test 5: reset in the middle of LOAD, then a fresh job.
    done_delay = 4;
    issue_cmd(10'h200, 11'd6, 10'h200, 11'd6);
    stream_in(3, 4);
    nreset = 1'b0;
    @(posedge clock);
    #1 nreset = 1'b1;
    @(negedge clock);
    check("t5_cmd_ready",  host.cmd_ready, 1);
    check("t5_in_ready",   host.in_ready, 0);
    check("t5_dmem_we_d",  dmem_we_d, 0);
    check("t5_cp_active",  cp_active, 0);
    check("t5_out_valid",  host.out_valid, 0);
    check("t5_job_done",   job_done, 0);
    @(posedge clock);
    #1;
    o0 = out_q.size(); d0 = done_cnt;
    issue_cmd(10'h210, 11'd3, 10'h210, 11'd3);
    stream_in(3, 5);
    wait_job_done("t5");
    check("t5_out_count", out_q.size() - o0, 3);
    for (int k = 0; k < 3; k++) check($sformatf("t5_out%0d", k), out_q[o0 + k], pat(5, k));
    check("t5_done_pulses", done_cnt - d0, 1);

    // Test 6: back-to-back jobs.
    o0 = out_q.size(); r0 = active_rises;
    issue_cmd(10'h020, 11'd2, 10'h020, 11'd2);
    stream_in(2, 6);
    wait_job_done("t6a");
    issue_cmd(10'h040, 11'd2, 10'h040, 11'd2);
    stream_in(2, 7);
    wait_job_done("t6b");
    check("t6_active_rises", active_rises - r0, 2);
    check("t6_out_count", out_q.size() - o0, 4);
    for (int k = 0; k < 2; k++) check($sformatf("t6a_out%0d", k), out_q[o0 + k], pat(6, k));
    for (int k = 0; k < 2; k++) check($sformatf("t6b_out%0d", k), out_q[o0 + 2 + k], pat(7, k));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
